// File: rtl/udc_timer_ctrl_pkg.sv
// Shared constants for the up/down counter timer controller:
// FSM state encodings, config register addresses and mode bit positions.
package udc_timer_ctrl_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // cfg_addr decode; address 3 is reserved
    localparam logic [1:0] ADDR_BASE = 2'd0;
    localparam logic [1:0] ADDR_PRE  = 2'd1;
    localparam logic [1:0] ADDR_MODE = 2'd2;

    // mode register bit positions
    localparam int unsigned MODE_W    = 2;
    localparam int unsigned MODE_DIR  = 0;
    localparam int unsigned MODE_AUTO = 1;

endpackage

// File: rtl/udc_timer_ctrl_counter.sv
// Up/down counter SFR: synchronous load with priority over increment/decrement.
// Ports: clk; ld loads D; incr/decr step Q by one; Q is the current count.
// No reset of its own: the controller drives ld=1, D=0 while in reset.
module udCounterSFR #(
    parameter int unsigned SIZE = 5
) (
    input  logic            clk,
    input  logic            ld,
    input  logic            incr,
    input  logic            decr,
    input  logic [SIZE-1:0] D,
    output logic [SIZE-1:0] Q
);

    always_ff @(posedge clk) begin
        if (ld)
            Q <= D;
        else if (incr)
            Q <= Q + SIZE'(1);
        else if (decr)
            Q <= Q - SIZE'(1);
    end

endmodule

// File: rtl/udc_timer_ctrl.sv
// Programmable timer controller around one up/down counter SFR.
// Holds base/prescale/mode config, sequences load and step strobes through a
// prescaler, and flags terminal count with a sticky irq.
// Ports: clk, rst (sync, active-high); cfg_we/cfg_addr/cfg_wdata config bus;
// start/stop/irq_clr control pulses; cnt_q count, irq flag, busy (LOAD/RUN),
// done (DONE).
module udc_timer_ctrl
    import udc_timer_ctrl_pkg::*;
#(
    parameter int unsigned SIZE  = 5,
    parameter int unsigned PRE_W = 4   // must not exceed SIZE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_we,
    input  logic [1:0]      cfg_addr,
    input  logic [SIZE-1:0] cfg_wdata,
    input  logic            start,
    input  logic            stop,
    input  logic            irq_clr,
    output logic [SIZE-1:0] cnt_q,
    output logic            irq,
    output logic            busy,
    output logic            done
);

    logic [1:0]        state, state_nxt;
    logic [SIZE-1:0]   base_q;
    logic [PRE_W-1:0]  pre_q;
    logic [MODE_W-1:0] mode_q;
    logic [PRE_W-1:0]  pre_cnt;

    logic            ld_c, incr_c, decr_c;
    logic [SIZE-1:0] d_c;
    logic            run_c, tick_c, at_term_c, term_ev_c, step_c;
    logic [SIZE-1:0] term_val_c;

    // Prescaler tick and terminal detection; stop masks both the step and the event
    always_comb begin
        run_c      = (state == ST_RUN);
        tick_c     = run_c && (pre_cnt == pre_q);
        term_val_c = mode_q[MODE_DIR] ? {SIZE{1'b1}} : {SIZE{1'b0}};
        at_term_c  = (cnt_q == term_val_c);
        term_ev_c  = tick_c && at_term_c && !stop;
        step_c     = tick_c && !at_term_c && !stop;
    end

    // Counter strobes; reset forces a load of zero
    always_comb begin
        ld_c   = rst || (state == ST_LOAD);
        d_c    = rst ? {SIZE{1'b0}} : base_q;
        incr_c = !rst && step_c && mode_q[MODE_DIR];
        decr_c = !rst && step_c && !mode_q[MODE_DIR];
    end

    // Next-state logic; stop outranks start and terminal
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_RUN;
            ST_RUN: begin
                if (stop)
                    state_nxt = ST_IDLE;
                else if (term_ev_c)
                    state_nxt = mode_q[MODE_AUTO] ? ST_LOAD : ST_DONE;
            end
            ST_DONE: begin
                if (stop)
                    state_nxt = ST_IDLE;
                else if (start)
                    state_nxt = ST_LOAD;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, prescaler, config, irq and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            base_q  <= '0;
            pre_q   <= '0;
            mode_q  <= '0;
            pre_cnt <= '0;
            irq     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == ST_LOAD) || (state_nxt == ST_RUN);
            done  <= (state_nxt == ST_DONE);

            // prescaler only runs while staying in RUN
            if (run_c && (state_nxt == ST_RUN) && !tick_c)
                pre_cnt <= pre_cnt + PRE_W'(1);
            else
                pre_cnt <= '0;

            if (cfg_we) begin
                case (cfg_addr)
                    ADDR_BASE: base_q <= cfg_wdata;
                    ADDR_PRE:  if (!busy) pre_q  <= cfg_wdata[PRE_W-1:0];
                    ADDR_MODE: if (!busy) mode_q <= cfg_wdata[MODE_W-1:0];
                    default: ;
                endcase
            end

            // set wins over clear
            if (term_ev_c)
                irq <= 1'b1;
            else if (irq_clr)
                irq <= 1'b0;
        end
    end

    udCounterSFR #(.SIZE(SIZE)) u_cnt (
        .clk  (clk),
        .ld   (ld_c),
        .incr (incr_c),
        .decr (decr_c),
        .D    (d_c),
        .Q    (cnt_q)
    );

endmodule

// File: tb/tb_udc_timer_ctrl.sv
// Directed bench for udc_timer_ctrl with hand-computed expected values.
module tb_udc_timer_ctrl;

    localparam int unsigned SIZE  = 5;
    localparam int unsigned PRE_W = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            cfg_we;
    logic [1:0]      cfg_addr;
    logic [SIZE-1:0] cfg_wdata;
    logic            start, stop, irq_clr;
    logic [SIZE-1:0] cnt_q;
    logic            irq, busy, done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    udc_timer_ctrl #(.SIZE(SIZE), .PRE_W(PRE_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .start     (start),
        .stop      (stop),
        .irq_clr   (irq_clr),
        .cnt_q     (cnt_q),
        .irq       (irq),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // advance one clock; sample 1ns after the rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [SIZE-1:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        cyc();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        start = 1'b0; stop = 1'b0; irq_clr = 1'b0;
        cyc();
        check("rst_cnt", int'(cnt_q), 0);
        check("rst_irq", int'(irq), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rst = 1'b0;

        // down count, no reload, base 3
        wr(2'd0, 5'd3); wr(2'd1, 5'd0); wr(2'd2, 5'd0);
        pulse_start();
        check("dn_load_busy", int'(busy), 1);
        for (int i = 3; i >= 0; i--) begin
            cyc();
            check("dn_cnt", int'(cnt_q), i);
        end
        cyc();
        check("dn_done", int'(done), 1);
        check("dn_irq", int'(irq), 1);
        check("dn_hold", int'(cnt_q), 0);
        check("dn_busy", int'(busy), 0);

        // irq_clr with no terminal event
        irq_clr = 1'b1; cyc(); irq_clr = 1'b0;
        check("clr_irq", int'(irq), 0);

        // up count, autoreload, prescale 2, base 29
        wr(2'd0, 5'd29); wr(2'd1, 5'd2); wr(2'd2, 5'd3);
        pulse_start();
        cyc();
        check("up_load", int'(cnt_q), 29);
        cyc(); check("up_p1", int'(cnt_q), 29);
        cyc(); check("up_p2", int'(cnt_q), 29);
        cyc(); check("up_s30", int'(cnt_q), 30);
        cyc(); cyc();
        check("up_p30", int'(cnt_q), 30);
        cyc(); check("up_s31", int'(cnt_q), 31);
        cyc(); cyc();
        check("up_irq_pre", int'(irq), 0);
        cyc();
        check("up_term_cnt", int'(cnt_q), 31);
        check("up_term_irq", int'(irq), 1);
        check("up_term_busy", int'(busy), 1);
        check("up_term_done", int'(done), 0);
        cyc();
        check("up_reload", int'(cnt_q), 29);
        check("up_reload_busy", int'(busy), 1);

        // config gating while busy: prescale ignored, base accepted
        wr(2'd1, 5'd5);
        check("gate_c1", int'(cnt_q), 29);
        wr(2'd0, 5'd7);
        check("gate_c2", int'(cnt_q), 29);
        cyc();
        check("gate_rate", int'(cnt_q), 30);
        irq_clr = 1'b1; cyc(); irq_clr = 1'b0;
        check("gate_clr", int'(irq), 0);
        cyc(); cyc();
        check("gate_s31", int'(cnt_q), 31);
        cyc(); cyc();
        // irq_clr coinciding with terminal tick
        irq_clr = 1'b1; cyc(); irq_clr = 1'b0;
        check("setclr_irq", int'(irq), 1);
        check("setclr_cnt", int'(cnt_q), 31);
        cyc();
        check("gate_base7", int'(cnt_q), 7);

        // stop and start together in RUN, on a tick cycle
        cyc(); cyc();
        stop = 1'b1; start = 1'b1; cyc(); stop = 1'b0; start = 1'b0;
        check("ss_cnt", int'(cnt_q), 7);
        check("ss_busy", int'(busy), 0);
        check("ss_done", int'(done), 0);
        cyc();
        check("ss_frozen", int'(cnt_q), 7);

        // stop on terminal tick suppresses irq
        irq_clr = 1'b1; cyc(); irq_clr = 1'b0;
        check("st_irq0", int'(irq), 0);
        wr(2'd0, 5'd31); wr(2'd2, 5'd1); wr(2'd1, 5'd0);
        wr(2'd3, 5'd2);   // reserved address, must not disturb anything
        pulse_start();
        cyc();
        check("st_load", int'(cnt_q), 31);
        stop = 1'b1; cyc(); stop = 1'b0;
        check("st_irq", int'(irq), 0);
        check("st_busy", int'(busy), 0);
        check("st_done", int'(done), 0);
        check("st_cnt", int'(cnt_q), 31);

        // base 1 down, terminal into DONE
        wr(2'd0, 5'd1); wr(2'd2, 5'd0);
        pulse_start();
        cyc(); check("b1_load", int'(cnt_q), 1);
        cyc(); check("b1_zero", int'(cnt_q), 0);
        cyc();
        check("b1_done", int'(done), 1);
        check("b1_irq", int'(irq), 1);

        // reset mid-run at count 12
        wr(2'd0, 5'd20);
        pulse_start();
        cyc(); check("mr_load", int'(cnt_q), 20);
        repeat (8) cyc();
        check("mr_cnt12", int'(cnt_q), 12);
        check("mr_busy", int'(busy), 1);
        rst = 1'b1; cyc(); rst = 1'b0;
        check("mr_cnt", int'(cnt_q), 0);
        check("mr_irq", int'(irq), 0);
        check("mr_busy0", int'(busy), 0);
        check("mr_done0", int'(done), 0);

        // config cleared: base 0, down, no reload, prescale 0 -> immediate terminal
        pulse_start();
        check("cz_busy", int'(busy), 1);
        cyc();
        check("cz_base", int'(cnt_q), 0);
        check("cz_irq_pre", int'(irq), 0);
        cyc();
        check("cz_done", int'(done), 1);
        check("cz_irq", int'(irq), 1);
        check("cz_cnt", int'(cnt_q), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/udc_timer_ctrl.md
# udc_timer_ctrl

Controller that sequences an up/down counter SFR as a programmable timer. It holds the reload base, prescaler and mode configuration written by the CPU, and drives the counter's load/increment/decrement strobes. It detects terminal count and raises a sticky interrupt flag. It sits between the CPU SFR bus and one counter instance.

## Interface
- SIZE, 5, counter/base width
- PRE_W, 4, prescaler width
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  config write strobe, one cycle
- cfg_addr  in  2  0=base, 1=prescale, 2=mode {autoreload, dir}; dir=1 up, dir=0 down; 3=reserved, writes ignored
- cfg_wdata  in  SIZE  write data, LSBs used for prescale and mode
- start  in  1  start pulse
- stop  in  1  stop pulse
- irq_clr  in  1  clears irq
- cnt_q  out  SIZE  current count
- irq  out  1  sticky terminal-count flag
- busy  out  1  high in LOAD or RUN
- done  out  1  high in DONE

## Operation
- States:
  - IDLE: waiting for start.
  - LOAD: drives ld=1, D=base for exactly one cycle.
  - RUN: counting.
  - DONE: holds count; exits to IDLE on stop, to LOAD on start.
- Transitions:
  - IDLE→LOAD on start.
  - LOAD→RUN unconditionally.
  - RUN→IDLE on stop.
  - RUN→LOAD on terminal with autoreload=1.
  - RUN→DONE on terminal with autoreload=0.
- Prescaler:
  - In RUN, pre_cnt counts 0..prescale, then wraps to 0.
  - tick=1 on the cycle pre_cnt==prescale, so one tick every prescale+1 cycles.
  - pre_cnt clears to 0 in every state other than RUN.
- Counting:
  - On tick, if not terminal: incr=dir, decr=~dir; the counter steps one.
  - Terminal value is {SIZE{1}} when counting up and 0 when counting down.
  - A tick while cnt_q equals the terminal value is the terminal event. No step is issued, so the counter never wraps.
  - Terminal event sets irq. irq stays high until an irq_clr cycle. If a terminal event and irq_clr occur in the same cycle, set wins.
- incr and decr are never both asserted. ld is asserted only in LOAD and during reset.
- Config writes:
  - base is accepted in any state and takes effect at the next LOAD.
  - prescale and mode writes are ignored while busy=1.
- Simultaneous events:
  - stop has priority over start and over a terminal event in the same cycle.
  - A terminal event suppressed by stop does not set irq.
  - start while busy is ignored.
- Reset (any state, including mid-run):
  - Go to IDLE.
  - base, prescale, mode, pre_cnt and irq go to 0.
  - Drive ld=1, D=0, so cnt_q=0 the cycle after reset is sampled.

## Timing
- Reset values: cnt_q=0 (one cycle after rst), irq=0, busy=0, done=0.
- start sampled at edge N: LOAD during cycle N+1; cnt_q=base and state RUN after edge N+2.
- With prescale=P, the first step after load appears P+1 cycles after RUN entry; later steps every P+1 cycles.
- Autoreload: terminal tick at edge T; LOAD in cycle T+1; cnt_q=base after edge T+2. Reload costs one cycle, in which the prescaler is held at 0.
- irq rises the cycle after the terminal tick edge. done rises in the same cycle.
- stop takes effect at the sampled edge; cnt_q freezes at its current value.

## Structure
- Shared package holds:
  - the state enum (IDLE, LOAD, RUN, DONE);
  - cfg_addr constants (ADDR_BASE=0, ADDR_PRE=1, ADDR_MODE=2);
  - mode bit indices (MODE_DIR=0, MODE_AUTO=1).
- One sub-module: a udCounterSFR instance with SIZE passed through, clocked by clk. The controller owns its ld/incr/decr/D pins.
- The prescaler and FSM stay inline in udc_timer_ctrl.

## Test plan
- Down count, no reload:
  - Stimulus: rst; write base=3, prescale=0, mode=0; start.
  - Required: cnt_q 3,2,1,0 on consecutive cycles; next cycle done=1, irq=1; cnt_q holds 0.
- Up count, autoreload, prescale:
  - Stimulus: base=29, prescale=2, mode=3, SIZE=5.
  - Required: steps every 3 cycles, 29→30→31; terminal causes one LOAD cycle; cnt_q=29 again; irq=1 and busy stays 1.
- irq handling:
  - irq_clr with no terminal event: irq drops the next cycle.
  - irq_clr in the same cycle as a terminal tick: irq stays 1.
- Stop/start conflicts:
  - stop and start together in RUN: state IDLE, cnt_q frozen.
  - stop on the terminal tick: irq stays 0.
- Config gating:
  - While busy, write prescale=5 and base=7.
  - Required: prescale unchanged (step rate unchanged); next reload loads 7.
- Reset mid-run:
  - Stimulus: rst while RUN with cnt_q=12.
  - Required: next cycle state IDLE, cnt_q=0, irq=0, busy=0; config registers read back 0.
